piece_mover: RTL and testbench

PIECE_MOVER -- requirements
Module: piece_mover

---
 rtl/piece_mover_pkg.sv | 25 ++
 rtl/piece_mover_tick_counter.sv | 41 ++++
 rtl/piece_mover.sv | 184 ++++++++++++++++++
 tb/tb_piece_mover.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/piece_mover_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piece_mover_pkg : playfield geometry, spawn position, mover states   |
// | Rev 1.0                                                             |
// +----------------------------------------------------------------------+
package piece_mover_pkg;

  localparam logic [9:0] CELL_PX    = 10'd16;
  localparam logic [9:0] LEFT_BOUND = 10'd240;
  localparam logic [9:0] GRID_W     = 10'd10;
  localparam logic [9:0] GRID_CELLS = 10'd300;

  localparam logic [9:0] SPAWN_X    = 10'd304;
  localparam logic [9:0] SPAWN_Y    = 10'd16;
  localparam logic [9:0] SPAWN_GRID = 10'd14;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FALL      = 2'd1,
    S_LOCK_WAIT = 2'd2,
    S_LOCKED    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/piece_mover_tick_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_counter : free-running counter with clear, enable and a        |
// | terminal-count pulse on the last tick; wraps to 0.   Rev 1.0        |
// +----------------------------------------------------------------------+
module tick_counter #(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int         W    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/piece_mover.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | piece_mover : moves the falling piece's reference cell under keys   |
// | and gravity; optional lock delay via macro LOCK_DELAY_EN. Rev 1.0   |
// +----------------------------------------------------------------------+
module piece_mover
  import piece_mover_pkg::*;
#(
  parameter int GRAVITY_TICKS = 25000000,
  parameter int LOCK_TICKS    = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spawn,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_down,
  input  logic       stop_left,
  input  logic       stop_right,
  input  logic       stop_down,
  output logic [9:0] ref_x,
  output logic [9:0] ref_y,
  output logic [9:0] gridNum,
  output logic       active,
  output logic       lock
);

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d, grid_q, grid_d;
  logic       left_q, right_q, down_q;
  logic       pend_q, pend_d;

  logic       in_play, in_fall;
  logic       left_edge, right_edge, down_edge;
  logic       mv_left, mv_right, h_move;
  logic       down_req, down_go, down_block;
  logic       grav_tc;

  assign in_fall = (state_q == S_FALL);
`ifdef LOCK_DELAY_EN
  assign in_play = in_fall || (state_q == S_LOCK_WAIT);
`else
  assign in_play = in_fall;
`endif

  assign left_edge  = key_left  & ~left_q;
  assign right_edge = key_right & ~right_q;
  assign down_edge  = key_down  & ~down_q;

  // Simultaneous left+right edges cancel each other out.
  assign mv_left  = in_play & left_edge  & ~right_edge & ~stop_left;
  assign mv_right = in_play & right_edge & ~left_edge  & ~stop_right;
  assign h_move   = mv_left | mv_right;

  // A down step colliding with a horizontal move is deferred one cycle.
  assign down_req   = in_fall & (down_edge | grav_tc | pend_q);
  assign down_go    = down_req & ~h_move & ~stop_down;
  assign down_block = down_req & ~h_move &  stop_down;
  assign pend_d     = down_req & h_move;

  tick_counter #(
    .TICKS   (GRAVITY_TICKS)
  ) u_gravity (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (~in_fall | down_go),
    .en_i    (in_fall),
    .tc_o    (grav_tc)
  );

`ifdef LOCK_DELAY_EN
  logic lock_tc;

  tick_counter #(
    .TICKS   (LOCK_TICKS)
  ) u_lock (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q != S_LOCK_WAIT),
    .en_i    (state_q == S_LOCK_WAIT),
    .tc_o    (lock_tc)
  );
`else
  logic unused_lock_ticks;
  assign unused_lock_ticks = (LOCK_TICKS > 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (spawn) state_d = S_FALL;
      end
      S_FALL: begin
`ifdef LOCK_DELAY_EN
        if (down_block) state_d = S_LOCK_WAIT;
`else
        if (down_block) state_d = S_LOCKED;
`endif
      end
`ifdef LOCK_DELAY_EN
      S_LOCK_WAIT: begin
        // A move this cycle changes the cell under test; re-check next cycle.
        if (!h_move) begin
          if (!stop_down)   state_d = S_FALL;
          else if (lock_tc) state_d = S_LOCKED;
        end
      end
`endif
      S_LOCKED: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    active = 1'b0;
    lock   = 1'b0;
    case (state_q)
      S_FALL:      active = 1'b1;
`ifdef LOCK_DELAY_EN
      S_LOCK_WAIT: active = 1'b1;
`endif
      S_LOCKED:    lock   = 1'b1;
      default:     ;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    grid_d = grid_q;
    if ((state_q == S_IDLE) && spawn) begin
      x_d    = SPAWN_X;
      y_d    = SPAWN_Y;
      grid_d = SPAWN_GRID;
    end
    if (mv_left) begin
      x_d    = x_q - CELL_PX;
      grid_d = grid_q - 10'd1;
    end
    if (mv_right) begin
      x_d    = x_q + CELL_PX;
      grid_d = grid_q + 10'd1;
    end
    if (down_go) begin
      y_d    = y_q + CELL_PX;
      grid_d = grid_q + GRID_W;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= SPAWN_X;
      y_q     <= SPAWN_Y;
      grid_q  <= SPAWN_GRID;
      pend_q  <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      down_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      grid_q  <= grid_d;
      pend_q  <= pend_d;
      left_q  <= key_left;
      right_q <= key_right;
      down_q  <= key_down;
    end
  end

  assign ref_x   = x_q;
  assign ref_y   = y_q;
  assign gridNum = grid_q;

endmodule
`default_nettype wire

// File: tb/tb_piece_mover.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_piece_mover : table-driven scoreboard bench for piece_mover      |
// | Rev 1.0                                                             |
// +----------------------------------------------------------------------+
module tb_piece_mover;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spawn, key_left, key_right, key_down;
  logic       stop_left, stop_right, stop_down;
  logic [9:0] ref_x, ref_y, gridNum;
  logic       active, lock;

  always #5 clk = ~clk;

  piece_mover #(
    .GRAVITY_TICKS (4),
    .LOCK_TICKS    (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spawn      (spawn),
    .key_left   (key_left),
    .key_right  (key_right),
    .key_down   (key_down),
    .stop_left  (stop_left),
    .stop_right (stop_right),
    .stop_down  (stop_down),
    .ref_x      (ref_x),
    .ref_y      (ref_y),
    .gridNum    (gridNum),
    .active     (active),
    .lock       (lock)
  );

  typedef struct {
    logic       sp, kl, kr, kd, sl, sr, sd;
    logic [9:0] x, y, g;
    logic       a, l;
  } rec_t;

  rec_t exp_q[$];
  rec_t tbl[23];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic rec_t mk(input logic sp, kl, kr, kd, sl, sr, sd,
                              input logic [9:0] x, y, g, input logic a, l);
    rec_t r;
    r.sp = sp; r.kl = kl; r.kr = kr; r.kd = kd;
    r.sl = sl; r.sr = sr; r.sd = sd;
    r.x = x; r.y = y; r.g = g; r.a = a; r.l = l;
    return r;
  endfunction

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, want);
  endtask

  task automatic chk_outs(input string tag, input rec_t e);
    chk({tag, ".ref_x"},   ref_x,          e.x);
    chk({tag, ".ref_y"},   ref_y,          e.y);
    chk({tag, ".gridNum"}, gridNum,        e.g);
    chk({tag, ".active"},  {9'd0, active}, {9'd0, e.a});
    chk({tag, ".lock"},    {9'd0, lock},   {9'd0, e.l});
  endtask

  // Drive one record at the falling edge, let one rising edge pass, compare.
  task automatic apply(input rec_t r, input string tag);
    rec_t e;
    spawn = r.sp; key_left = r.kl; key_right = r.kr; key_down = r.kd;
    stop_left = r.sl; stop_right = r.sr; stop_down = r.sd;
    exp_q.push_back(r);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    chk_outs(tag, e);
  endtask

  initial begin
    //            sp kl kr kd sl sr sd   x    y    g   a  l
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 304,  16,  14, 1, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0, 288,  16,  13, 1, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0, 288,  16,  13, 1, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0, 288,  16,  13, 1, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 0, 288,  32,  23, 1, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 288,  32,  23, 1, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0, 288,  32,  23, 1, 0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 0, 288,  32,  23, 1, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0, 288,  48,  33, 1, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0, 288,  48,  33, 1, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 0, 288,  48,  33, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 288,  48,  33, 1, 0);
    tbl[12] = mk(0, 1, 1, 0, 0, 0, 0, 288,  64,  43, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 288,  64,  43, 1, 0);
    tbl[14] = mk(0, 0, 1, 0, 0, 1, 0, 288,  64,  43, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 288,  64,  43, 1, 0);
    tbl[16] = mk(0, 0, 1, 0, 0, 0, 0, 304,  64,  44, 1, 0);
    tbl[17] = mk(0, 0, 1, 0, 0, 0, 0, 304,  80,  54, 1, 0);
    tbl[18] = mk(0, 0, 0, 1, 0, 0, 0, 304,  96,  64, 1, 0);
    tbl[19] = mk(0, 0, 0, 1, 0, 0, 0, 304,  96,  64, 1, 0);
    tbl[20] = mk(0, 1, 0, 0, 1, 0, 0, 304,  96,  64, 1, 0);
    tbl[21] = mk(1, 0, 0, 0, 0, 0, 0, 304,  96,  64, 1, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 304, 112,  74, 1, 0);

    rst_n = 1'b0;
    spawn = 0; key_left = 0; key_right = 0; key_down = 0;
    stop_left = 0; stop_right = 0; stop_down = 0;
    repeat (2) @(negedge clk);
    chk_outs("reset", mk(0, 0, 0, 0, 0, 0, 0, 304, 16, 14, 0, 0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 23; i++) apply(tbl[i], $sformatf("row%0d", i));

`ifdef LOCK_DELAY_EN
    for (int i = 0; i < 4; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 1, 304, 112, 74, 1, 0), $sformatf("lw_enter%0d", i));
    apply(mk(0, 0, 1, 0, 0, 0, 1, 320, 112, 75, 1, 0), "lw_move");
    apply(mk(0, 0, 1, 0, 0, 0, 0, 320, 112, 75, 1, 0), "lw_release");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 320, 112, 75, 1, 0), "lw_back_fall");
    apply(mk(0, 0, 0, 1, 0, 0, 1, 320, 112, 75, 1, 0), "lw_reenter");
    apply(mk(0, 0, 0, 1, 0, 0, 1, 320, 112, 75, 1, 0), "lw_wait1");
    apply(mk(0, 0, 0, 1, 0, 0, 1, 320, 112, 75, 1, 0), "lw_wait2");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 320, 112, 75, 0, 1), "lw_locked");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 320, 112, 75, 0, 0), "lw_idle");
`else
    for (int i = 0; i < 3; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 1, 304, 112, 74, 1, 0), $sformatf("lk_fall%0d", i));
    apply(mk(0, 0, 0, 0, 0, 0, 1, 304, 112, 74, 0, 1), "lk_pulse");
    apply(mk(0, 0, 0, 0, 0, 0, 1, 304, 112, 74, 0, 0), "lk_idle");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 304, 112, 74, 0, 0), "lk_idle2");
`endif

    apply(mk(1, 0, 0, 0, 0, 0, 0, 304, 16, 14, 1, 0), "rs_spawn");
    apply(mk(0, 1, 0, 0, 0, 0, 0, 288, 16, 13, 1, 0), "rs_move");
    #2 rst_n = 1'b0;
    #1 chk_outs("rs_async", mk(0, 0, 0, 0, 0, 0, 0, 304, 16, 14, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 304, 16, 14, 0, 0), "rs_after1");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 304, 16, 14, 0, 0), "rs_after2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
